alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_if.sv | 27 ++
 rtl/alu_muldiv_iter.sv | 82 ++++++++
 rtl/alu_mc.sv | 190 +++++++++++++++++++
 tb/tb_alu_mc.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and control state for the multi-cycle ALU.
package alu_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FLAGS_W  = 5;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_OR   = 7'd0;
    localparam opcode_t OP_AND  = 7'd1;
    localparam opcode_t OP_XOR  = 7'd2;
    localparam opcode_t OP_ADD  = 7'd3;
    localparam opcode_t OP_SUB  = 7'd4;
    localparam opcode_t OP_SHL1 = 7'd5;
    localparam opcode_t OP_SHR1 = 7'd6;
    localparam opcode_t OP_INC  = 7'd7;
    localparam opcode_t OP_DEC  = 7'd8;
    localparam opcode_t OP_ZERO = 7'd9;
    localparam opcode_t OP_NOT  = 7'd10;
    localparam opcode_t OP_PASS = 7'd11;
    localparam opcode_t OP_NEG  = 7'd12;
    localparam opcode_t OP_SHL  = 7'd13;
    localparam opcode_t OP_SHR  = 7'd14;
    localparam opcode_t OP_SAR  = 7'd15;
    localparam opcode_t OP_MUL  = 7'd16;
    localparam opcode_t OP_DIVU = 7'd17;
    localparam opcode_t OP_REMU = 7'd18;

    localparam int unsigned FLAG_C = 4;
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_P = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_if.sv
// Request/response bundle between an ALU client (master) and the ALU (slave).
interface alu_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    opcode_t            opcode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic [FLAGS_W-1:0] flags;
    logic               err;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, result, flags, err
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, result, flags, err
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Bit-serial unsigned multiply (shift-add) and restoring divide, one iteration per cycle.
// Results are presented as the post-final-iteration values while done_o is high.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic             busy_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // acc: partial product / partial remainder; x: multiplier / dividend-quotient; y: multiplicand / divisor
    always_comb begin
        acc_d  = acc_q;
        x_d    = x_q;
        y_d    = y_q;
        rem_sh = {acc_q, x_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, y_q};
        if (div_q) begin
            x_d   = {x_q[WIDTH-2:0], 1'b0};
            acc_d = rem_sh[WIDTH-1:0];
            if (rem_sh >= {1'b0, y_q}) begin
                acc_d   = diff[WIDTH-1:0];
                x_d[0]  = 1'b1;
            end
        end else begin
            acc_d = acc_q + (x_q[0] ? y_q : '0);
            x_d   = x_q >> 1;
            y_d   = y_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            div_q  <= div_i;
            cnt_q  <= '0;
            acc_q  <= '0;
            x_q    <= a_i;
            y_q    <= b_i;
        end else if (busy_q) begin
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign product_o   = acc_d;
    assign quotient_o  = x_d;
    assign remainder_o = acc_d;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIVU/REMU,
// valid/ready handshake on both sides, all outputs registered.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst,
    alu_if.slave   bus
);
    localparam int unsigned SH_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic               in_ready_q;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic               err_q, err_d;
    opcode_t            md_op_q;
    logic               md_bzero_q;

    logic               accept_c, is_md_c, md_start_c;
    logic               md_busy, md_done;
    logic [WIDTH-1:0]   md_prod, md_quo, md_rem, md_res;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_carry, sc_ovf, sc_err;
    logic [WIDTH:0]     wide;
    logic [SH_W-1:0]    sh;

    function automatic logic [FLAGS_W-1:0] mk_flags(input logic [WIDTH-1:0] r,
                                                    input logic c, input logic v);
        logic [FLAGS_W-1:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_P] = ~^r;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign accept_c   = bus.in_valid & in_ready_q;
    assign is_md_c    = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIVU) || (bus.opcode == OP_REMU);
    assign md_start_c = accept_c & is_md_c & ~md_busy;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .start_i     (md_start_c),
        .div_i       (bus.opcode != OP_MUL),
        .a_i         (bus.a),
        .b_i         (bus.b),
        .busy_o      (md_busy),
        .done_o      (md_done),
        .product_o   (md_prod),
        .quotient_o  (md_quo),
        .remainder_o (md_rem)
    );

    // Single-cycle datapath; carry/overflow follow unsigned-borrow and two's-complement rules
    always_comb begin
        sh       = bus.b[SH_W-1:0];
        wide     = '0;
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_err   = 1'b0;
        case (bus.opcode)
            OP_OR:   sc_res = bus.a | bus.b;
            OP_AND:  sc_res = bus.a & bus.b;
            OP_XOR:  sc_res = bus.a ^ bus.b;
            OP_ADD: begin
                wide     = {1'b0, bus.a} + {1'b0, bus.b};
                sc_res   = wide[WIDTH-1:0];
                sc_carry = wide[WIDTH];
                sc_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sc_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = bus.a - bus.b;
                sc_carry = bus.a < bus.b;
                sc_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sc_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SHL1: begin
                sc_res   = {bus.a[WIDTH-2:0], 1'b0};
                sc_carry = bus.a[WIDTH-1];
            end
            OP_SHR1: sc_res = bus.a >> 1;
            OP_INC: begin
                wide     = {1'b0, bus.a} + (WIDTH+1)'(1);
                sc_res   = wide[WIDTH-1:0];
                sc_carry = wide[WIDTH];
                sc_ovf   = ~bus.a[WIDTH-1] & sc_res[WIDTH-1];
            end
            OP_DEC: begin
                sc_res   = bus.a - WIDTH'(1);
                sc_carry = (bus.a == '0);
                sc_ovf   = bus.a[WIDTH-1] & ~sc_res[WIDTH-1];
            end
            OP_ZERO: sc_res = '0;
            OP_NOT:  sc_res = ~bus.a;
            OP_PASS: sc_res = bus.a;
            OP_NEG: begin
                sc_res = '0 - bus.a;
                sc_ovf = bus.a[WIDTH-1] & sc_res[WIDTH-1];
            end
            OP_SHL: begin
                wide     = {1'b0, bus.a} << sh;
                sc_res   = wide[WIDTH-1:0];
                sc_carry = wide[WIDTH];
            end
            OP_SHR:  sc_res = bus.a >> sh;
            OP_SAR:  sc_res = WIDTH'($signed(bus.a) >>> sh);
            OP_MUL, OP_DIVU, OP_REMU: sc_res = '0;
            default: sc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == ST_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = is_md_c ? ST_BUSY : ST_DONE;
            ST_BUSY: if (md_done) state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        err_d       = err_q;
        md_res      = (md_op_q == OP_MUL)  ? md_prod :
                      (md_op_q == OP_DIVU) ? md_quo  : md_rem;
        case (state_q)
            ST_IDLE: if (accept_c && !is_md_c) begin
                out_valid_d = 1'b1;
                result_d    = sc_res;
                flags_d     = mk_flags(sc_res, sc_carry, sc_ovf);
                err_d       = sc_err;
            end
            ST_BUSY: if (md_done) begin
                out_valid_d = 1'b1;
                result_d    = md_res;
                flags_d     = mk_flags(md_res, 1'b0, 1'b0);
                err_d       = md_bzero_q && (md_op_q != OP_MUL);
            end
            ST_DONE: if (bus.out_ready) out_valid_d = 1'b0;
            default: out_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            md_op_q     <= OP_OR;
            md_bzero_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            if (accept_c) begin
                md_op_q    <= bus.opcode;
                md_bzero_q <= (bus.b == '0);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH = 32): directed vector table, reset/abort sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int unsigned W = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;

    alu_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [6:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          stall;
        logic [31:0] res;
        logic [4:0]  flg;
        logic        err;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the operation definitions
    function automatic void model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f,
                                  output logic e, output int lat);
        longint unsigned ua, ub, full;
        longint sa, sb, s;
        int sh;
        logic c, v;
        ua = 64'(a); ub = 64'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        sh = int'(b % 32);
        c = 1'b0; v = 1'b0; e = 1'b0; lat = 1; r = '0; full = 0; s = 0;
        case (op)
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_ADD:  begin full = ua + ub; r = full[31:0]; c = full[32]; s = sa + sb; v = (s > MAXS) || (s < MINS); end
            OP_SUB:  begin full = ua - ub; r = full[31:0]; c = (ua < ub); s = sa - sb; v = (s > MAXS) || (s < MINS); end
            OP_SHL1: begin full = ua * 2; r = full[31:0]; c = full[32]; end
            OP_SHR1: r = a / 2;
            OP_INC:  begin full = ua + 1; r = full[31:0]; c = full[32]; s = sa + 1; v = (s > MAXS); end
            OP_DEC:  begin full = ua - 1; r = full[31:0]; c = (ua < 1); s = sa - 1; v = (s < MINS); end
            OP_ZERO: r = '0;
            OP_NOT:  r = ~a;
            OP_PASS: r = a;
            OP_NEG:  begin s = -sa; r = s[31:0]; v = (s > MAXS); end
            OP_SHL:  begin full = ua << sh; r = full[31:0]; c = (sh != 0) ? full[32] : 1'b0; end
            OP_SHR:  begin full = ua >> sh; r = full[31:0]; end
            OP_SAR:  begin s = sa >>> sh; r = s[31:0]; end
            OP_MUL:  begin full = ua * ub; r = full[31:0]; lat = W + 1; end
            OP_DIVU: begin lat = W + 1; if (b == 0) begin r = '1; e = 1'b1; end else begin full = ua / ub; r = full[31:0]; end end
            OP_REMU: begin lat = W + 1; if (b == 0) begin r = a; e = 1'b1; end else begin full = ua % ub; r = full[31:0]; end end
            default: begin r = '0; e = 1'b1; end
        endcase
        f = {c, r[31], (r == 0), ~^r, v};
    endfunction

    // One transaction: accept, measure latency, check outputs, hold for 'stall' cycles, retire
    task automatic run_op(input string tag, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input logic [31:0] er, input logic [4:0] ef,
                          input logic ee, input int el);
        int lat, guard, rdy_hi, bad;
        logic [31:0] r0;
        logic [4:0] f0;
        logic e0;
        bit ok;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.opcode = op; bus.a = a; bus.b = b; bus.out_ready = 1'b0;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            check({tag, "_accept_timeout"}, 64'd0, 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.opcode = 7'($urandom_range(0, 127));
        lat = 0; rdy_hi = 0; ok = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.in_ready) rdy_hi++;
            if (bus.out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check({tag, "_valid_timeout"}, 64'd0, 64'd1);
            return;
        end
        check({tag, "_latency"}, 64'(lat), 64'(el));
        check({tag, "_result"}, 64'(bus.result), 64'(er));
        check({tag, "_flags"}, 64'(bus.flags), 64'(ef));
        check({tag, "_err"}, 64'(bus.err), 64'(ee));
        check({tag, "_ready_low"}, 64'(rdy_hi), 64'd0);
        r0 = bus.result; f0 = bus.flags; e0 = bus.err;
        bad = 0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.result !== r0 || bus.flags !== f0 || bus.err !== e0) bad++;
        end
        if (stall > 0) check({tag, "_hold"}, 64'(bad), 64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_retire"}, 64'({bus.out_valid, bus.in_ready}), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        logic [31:0] specials[6];
        logic [31:0] ra, rb, xr;
        logic [4:0]  xf;
        logic [6:0]  rop;
        logic        xe;
        int          xl, seen;

        tbl.push_back('{"add_wrap",  OP_ADD,  32'hFFFFFFFF, 32'h1,        0, 32'h0,        5'b10110, 1'b0, 1});
        tbl.push_back('{"add_ovf",   OP_ADD,  32'h7FFFFFFF, 32'h1,        0, 32'h80000000, 5'b01001, 1'b0, 1});
        tbl.push_back('{"mul",       OP_MUL,  32'h00010001, 32'h00010001, 0, 32'h00020001, 5'b00010, 1'b0, 33});
        tbl.push_back('{"divu_z",    OP_DIVU, 32'd100,      32'd0,        1, 32'hFFFFFFFF, 5'b01010, 1'b1, 33});
        tbl.push_back('{"remu",      OP_REMU, 32'd100,      32'd7,        0, 32'd2,        5'b00000, 1'b0, 33});
        tbl.push_back('{"divu",      OP_DIVU, 32'd100,      32'd7,        0, 32'd14,       5'b00000, 1'b0, 33});
        tbl.push_back('{"sar_hold",  OP_SAR,  32'h80000000, 32'd4,        5, 32'hF8000000, 5'b01000, 1'b0, 1});
        tbl.push_back('{"sub_borrow",OP_SUB,  32'h0,        32'h1,        0, 32'hFFFFFFFF, 5'b11010, 1'b0, 1});
        tbl.push_back('{"sub_ovf",   OP_SUB,  32'h80000000, 32'h1,        0, 32'h7FFFFFFF, 5'b00001, 1'b0, 1});
        tbl.push_back('{"neg_min",   OP_NEG,  32'h80000000, 32'h0,        0, 32'h80000000, 5'b01001, 1'b0, 1});
        tbl.push_back('{"shl_zero",  OP_SHL,  32'h80000001, 32'd0,        0, 32'h80000001, 5'b01010, 1'b0, 1});
        tbl.push_back('{"shl_mod",   OP_SHL,  32'h80000001, 32'd33,       0, 32'h00000002, 5'b10000, 1'b0, 1});
        tbl.push_back('{"illegal",   7'd19,   32'd5,        32'd9,        2, 32'h0,        5'b00110, 1'b1, 1});
        tbl.push_back('{"dec_zero",  OP_DEC,  32'h0,        32'h0,        0, 32'hFFFFFFFF, 5'b11010, 1'b0, 1});
        tbl.push_back('{"inc_wrap",  OP_INC,  32'hFFFFFFFF, 32'h0,        0, 32'h0,        5'b10110, 1'b0, 1});
        tbl.push_back('{"shl1",      OP_SHL1, 32'hC0000000, 32'h0,        0, 32'h80000000, 5'b11000, 1'b0, 1});
        tbl.push_back('{"zero",      OP_ZERO, 32'd123,      32'd77,       0, 32'h0,        5'b00110, 1'b0, 1});

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.opcode = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_flags", 64'(bus.flags), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_op(tbl[i].tag, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].stall,
                   tbl[i].res, tbl[i].flg, tbl[i].err, tbl[i].lat);
        end

        // Reset during DIVU iterations aborts it silently
        @(negedge clk);
        bus.in_valid = 1'b1; bus.opcode = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        run_op("after_abort_add", OP_ADD, 32'd2, 32'd3, 0, 32'd5, 5'b00010, 1'b0, 1);

        // Reset dominates a simultaneous request
        @(negedge clk);
        rst = 1'b1; bus.in_valid = 1'b1; bus.opcode = OP_ADD; bus.a = 32'd1; bus.b = 32'd1; bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) seen++;
        end
        check("rst_dominates", 64'(seen), 64'd0);

        specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd31};
        for (int i = 0; i < 120; i++) begin
            rop = 7'($urandom_range(0, 21));
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
            model(rop, ra, rb, xr, xf, xe, xl);
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, int'($urandom_range(0, 2)), xr, xf, xe, xl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
